// File: rtl/alu_issue_queue.sv
// rtl/alu_issue_queue.sv - ALU issue queue: buffers uops, snoops regfile writes, issues oldest ready uop (optional stats: ALU_IQ_STATS_EN)
package alu_iq_pkg;
    localparam int XLEN      = 32;
    localparam int IQ_PREG_W = 6;

    typedef struct packed {
        logic                 valid;
        logic [3:0]           op;
        logic [IQ_PREG_W-1:0] rd;
        logic [XLEN-1:0]      r0_val;
        logic [XLEN-1:0]      r1_val;
        logic [XLEN-1:0]      r2_val;
    } rob_issue_t;

    typedef struct packed {
        logic                 en;
        logic [IQ_PREG_W-1:0] index_in;
        logic [XLEN-1:0]      data_in;
    } reg_file_write_port_t;
endpackage

module alu_issue_queue
    import alu_iq_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int NUM_WB = 2,
    parameter int PREG_W = IQ_PREG_W
) (
    input  logic                              clk_in,
    input  logic                              rst_in,
    input  logic                              enq_valid_in,
    input  rob_issue_t                        enq_insn_in,
    input  logic [2:0][PREG_W-1:0]            enq_src_phys_in,
    input  logic [2:0]                        enq_src_rdy_in,
    output logic                              enq_ready_out,
    input  reg_file_write_port_t [NUM_WB-1:0] wb_in,
    input  logic                              alu_ready_in,
    output rob_issue_t                        issue_out,
    input  logic                              flush_in
`ifdef ALU_IQ_STATS_EN
    ,
    output logic [31:0]                       stat_issued_out,
    output logic [31:0]                       stat_stall_out
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic                   valid_q [DEPTH];
    logic                   valid_d [DEPTH];
    logic [AW-1:0]          age_q   [DEPTH];
    logic [AW-1:0]          age_d   [DEPTH];
    rob_issue_t             insn_q  [DEPTH];
    rob_issue_t             insn_d  [DEPTH];
    logic [2:0][PREG_W-1:0] phys_q  [DEPTH];
    logic [2:0][PREG_W-1:0] phys_d  [DEPTH];
    logic [2:0]             rdy_q   [DEPTH];
    logic [2:0]             rdy_d   [DEPTH];
    logic [2:0][XLEN-1:0]   val_q   [DEPTH];
    logic [2:0][XLEN-1:0]   val_d   [DEPTH];
    logic [CW-1:0]          count_q, count_d;
    rob_issue_t             issue_q, issue_d;

    logic          cand;
    logic [AW-1:0] sel, sel_age;
    logic          have_free;
    logic [AW-1:0] free_idx;
    logic          do_iss, do_enq;

    assign enq_ready_out = (count_q < CW'(DEPTH));
    assign issue_out     = issue_q;

    // Pick the oldest fully-ready entry (registered readiness only) and the first free slot
    always_comb begin
        cand      = 1'b0;
        sel       = '0;
        sel_age   = '1;
        have_free = 1'b0;
        free_idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (&rdy_q[i]) && (!cand || age_q[i] < sel_age)) begin
                cand    = 1'b1;
                sel     = AW'(i);
                sel_age = age_q[i];
            end
            if (!valid_q[i] && !have_free) begin
                have_free = 1'b1;
                free_idx  = AW'(i);
            end
        end
        do_iss = cand && alu_ready_in && !flush_in;
        do_enq = enq_valid_in && enq_ready_out && have_free && !flush_in;
    end

    // Entry next state: wakeup snoop, age compaction on issue, enqueue, flush
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            valid_d[i] = valid_q[i];
            age_d[i]   = age_q[i];
            insn_d[i]  = insn_q[i];
            phys_d[i]  = phys_q[i];
            rdy_d[i]   = rdy_q[i];
            val_d[i]   = val_q[i];
            if (do_enq && free_idx == AW'(i)) begin
                valid_d[i] = 1'b1;
                age_d[i]   = AW'(count_q - CW'(do_iss));
                insn_d[i]  = enq_insn_in;
                phys_d[i]  = enq_src_phys_in;
                rdy_d[i]   = enq_src_rdy_in;
                val_d[i][0] = enq_insn_in.r0_val;
                val_d[i][1] = enq_insn_in.r1_val;
                val_d[i][2] = enq_insn_in.r2_val;
            end else if (do_iss && valid_q[i] && age_q[i] > sel_age) begin
                age_d[i] = age_q[i] - 1'b1;
            end
            // Wakeup also covers an entry being written this cycle, so no write is lost
            for (int s = 0; s < 3; s++) begin
                for (int k = 0; k < NUM_WB; k++) begin
                    if (valid_d[i] && !rdy_d[i][s] && wb_in[k].en &&
                        phys_d[i][s] != '0 && wb_in[k].index_in == phys_d[i][s]) begin
                        rdy_d[i][s] = 1'b1;
                        val_d[i][s] = wb_in[k].data_in;
                    end
                end
            end
            if (do_iss && sel == AW'(i)) valid_d[i] = 1'b0;
            if (flush_in) valid_d[i] = 1'b0;
        end
        count_d = flush_in ? '0 : count_q + CW'(do_enq) - CW'(do_iss);
        issue_d = '0;
        if (do_iss) begin
            issue_d        = insn_q[sel];
            issue_d.valid  = 1'b1;
            issue_d.r0_val = val_q[sel][0];
            issue_d.r1_val = val_q[sel][1];
            issue_d.r2_val = val_q[sel][2];
        end
    end

    // Control state: entry valid bits, occupancy and the issue register
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < DEPTH; i++) valid_q[i] <= 1'b0;
            count_q <= '0;
            issue_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) valid_q[i] <= valid_d[i];
            count_q <= count_d;
            issue_q <= issue_d;
        end
    end

    // Entry payload needs no reset; it is qualified by valid_q
    always_ff @(posedge clk_in) begin
        for (int i = 0; i < DEPTH; i++) begin
            age_q[i]  <= age_d[i];
            insn_q[i] <= insn_d[i];
            phys_q[i] <= phys_d[i];
            rdy_q[i]  <= rdy_d[i];
            val_q[i]  <= val_d[i];
        end
    end

`ifdef ALU_IQ_STATS_EN
    logic [31:0] stat_issued_q, stat_stall_q;
    assign stat_issued_out = stat_issued_q;
    assign stat_stall_out  = stat_stall_q;

    // Issue and stall counters survive flush, wrap naturally
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            stat_issued_q <= '0;
            stat_stall_q  <= '0;
        end else begin
            if (do_iss) stat_issued_q <= stat_issued_q + 32'd1;
            if (count_q != '0 && !cand && alu_ready_in) stat_stall_q <= stat_stall_q + 32'd1;
        end
    end
`endif
endmodule
